spio_spinnaker_link_sync_to_async_fifo: RTL and testbench

//  Transmit side of the SpiNNaker link: buffers 2-of-7 RTZ flits from the sync

---
 rtl/spio_spinnaker_link_sync_to_async_fifo.sv | 173 +++++++++++++++++
 tb/tb_spio_spinnaker_link_sync_to_async_fifo.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spio_spinnaker_link_sync_to_async_fifo.sv
// spio_spinnaker_link_sync_to_async_fifo
// Transmit side of a SpiNNaker link. Buffers 2-of-7 RTZ flits from the packet
// serializer and drives them onto the link as NRZ 2-of-7 transitions, holding
// each flit until the remote end toggles its ack.
// Optional feature: define SPIO_SL_TX_TIMEOUT_EN to add a sticky ack-timeout
// detector; without it the transmitter waits for an ack indefinitely.
module spio_spinnaker_link_sync_to_async_fifo #(
    parameter int ADDR_WIDTH     = 2,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic       CLK_IN,
    input  logic       RESET_N_IN,
    input  logic [6:0] flt_data_2of7,
    input  logic       flt_vld,
    output logic       flt_rdy,
    output logic [6:0] SL_DATA_2OF7_OUT,
    input  logic       SL_ACK_IN,
    output logic       TIMEOUT_ERR_OUT
);

    localparam int BUFF_DEPTH = 2 ** ADDR_WIDTH;
    localparam int SCW        = $clog2(SYNC_STAGES + 1);

    // Reject configurations that cannot work at elaboration time.
    if (SYNC_STAGES < 2 || TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("SYNC_STAGES and TIMEOUT_CYCLES must both be at least 2");
    end

    typedef enum logic [1:0] {
        ST_SYNC     = 2'd0,
        ST_IDLE     = 2'd1,
        ST_WAIT_ACK = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic [ADDR_WIDTH:0]      wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0]      rd_ptr_q, rd_ptr_d;
    logic [6:0]               data_q, data_d;
    logic [SYNC_STAGES-1:0]   ack_sync_q, ack_sync_d;
    logic                     ack_last_q, ack_last_d;
    logic [SCW-1:0]           sync_cnt_q, sync_cnt_d;
    logic [6:0]               fifo_mem [BUFF_DEPTH];

    logic full, empty, wr_en, ack_sync, ack_chg, send;

`ifdef SPIO_SL_TX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          err_q, err_d;
    assign TIMEOUT_ERR_OUT = err_q;
`else
    assign TIMEOUT_ERR_OUT = 1'b0;
`endif

    // Full when the wrap bits differ but the addresses match.
    assign full  = (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]) &&
                   (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]);
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign flt_rdy = !full && (state_q != ST_SYNC);
    // Symbols that are not exactly 2-hot are consumed but never stored.
    assign wr_en = flt_vld && flt_rdy && ($countones(flt_data_2of7) == 2);

    assign ack_sync = ack_sync_q[SYNC_STAGES-1];
    assign ack_chg  = ack_sync ^ ack_last_q;
    assign ack_sync_d = {ack_sync_q[SYNC_STAGES-2:0], SL_ACK_IN};
    assign SL_DATA_2OF7_OUT = data_q;

    // Next-state logic for the FSM, FIFO pointers and NRZ output.
    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        data_d     = data_q;
        ack_last_d = ack_last_q;
        sync_cnt_d = sync_cnt_q;
        send       = 1'b0;
`ifdef SPIO_SL_TX_TIMEOUT_EN
        tmo_cnt_d  = tmo_cnt_q;
        err_d      = err_q;
`endif
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        case (state_q)
            ST_SYNC: begin
                // Track the ack continuously so the remote reset-exit toggle is absorbed.
                ack_last_d = ack_sync;
                if (sync_cnt_q == SCW'(SYNC_STAGES)) begin
                    state_d = ST_IDLE;
                end else begin
                    sync_cnt_d = sync_cnt_q + 1'b1;
                end
            end
            ST_IDLE: begin
                if (ack_chg) begin
                    ack_last_d = ack_sync;
                end
                if (!empty) begin
                    send    = 1'b1;
                    state_d = ST_WAIT_ACK;
                end
            end
            ST_WAIT_ACK: begin
                if (ack_chg) begin
                    ack_last_d = ack_sync;
                    if (!empty) begin
                        send = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
`ifdef SPIO_SL_TX_TIMEOUT_EN
                else if (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    // Give up on this flit; it is lost and the output is left as is.
                    err_d      = 1'b1;
                    state_d    = ST_IDLE;
                    ack_last_d = ack_sync;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
`endif
            end
            default: state_d = ST_SYNC;
        endcase
        if (send) begin
            data_d   = data_q ^ fifo_mem[rd_ptr_q[ADDR_WIDTH-1:0]];
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
`ifdef SPIO_SL_TX_TIMEOUT_EN
        if (send || ack_chg) begin
            tmo_cnt_d = '0;
        end
`endif
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge CLK_IN or negedge RESET_N_IN) begin
        if (!RESET_N_IN) begin
            state_q    <= ST_SYNC;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            data_q     <= '0;
            ack_sync_q <= '0;
            ack_last_q <= 1'b0;
            sync_cnt_q <= '0;
`ifdef SPIO_SL_TX_TIMEOUT_EN
            tmo_cnt_q  <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            data_q     <= data_d;
            ack_sync_q <= ack_sync_d;
            ack_last_q <= ack_last_d;
            sync_cnt_q <= sync_cnt_d;
`ifdef SPIO_SL_TX_TIMEOUT_EN
            tmo_cnt_q  <= tmo_cnt_d;
            err_q      <= err_d;
`endif
        end
    end

    // Flit storage; contents need no reset because the pointers define validity.
    always_ff @(posedge CLK_IN) begin
        if (wr_en) begin
            fifo_mem[wr_ptr_q[ADDR_WIDTH-1:0]] <= flt_data_2of7;
        end
    end

endmodule

// File: tb/tb_spio_spinnaker_link_sync_to_async_fifo.sv
// Bench for spio_spinnaker_link_sync_to_async_fifo: random 2-of-7 flits, a
// receiver model that acks each observed transition, and a queue of expected flits.
module tb_spio_spinnaker_link_sync_to_async_fifo;

    localparam int TC = 1024;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       vld   = 1'b0;
    logic       ack   = 1'b0;
    logic [6:0] din   = 7'd0;
    logic       rdy;
    logic       err;
    logic [6:0] dout;

    spio_spinnaker_link_sync_to_async_fifo #(
        .ADDR_WIDTH    (2),
        .SYNC_STAGES   (2),
        .TIMEOUT_CYCLES(TC)
    ) dut (
        .CLK_IN          (clk),
        .RESET_N_IN      (rst_n),
        .flt_data_2of7   (din),
        .flt_vld         (vld),
        .flt_rdy         (rdy),
        .SL_DATA_2OF7_OUT(dout),
        .SL_ACK_IN       (ack),
        .TIMEOUT_ERR_OUT (err)
    );

    always #5 clk = ~clk;

    int         total = 0;
    int         bad   = 0;
    logic [6:0] exp_q [$];
    logic [6:0] prev_out = 7'd0;
    bit         pending  = 1'b0;
    bit         ack_en   = 1'b0;
    int         ack_dly  = 0;
    int         sent     = 0;

    function automatic logic [6:0] rand_flit();
        logic [6:0] f;
        int a;
        int b;
        a = $urandom_range(0, 6);
        b = $urandom_range(0, 6);
        while (b == a) b = $urandom_range(0, 6);
        f = 7'd0;
        f[a] = 1'b1;
        f[b] = 1'b1;
        return f;
    endfunction

    // One clock: sample at the falling edge, check any link transition, run the receiver.
    task automatic tick();
        logic [6:0] exp_v;
        @(negedge clk);
        if (dout !== prev_out) begin
            sent++;
            total++;
            if (pending) begin
                bad++;
                $display("FAIL two_outstanding: out=%h while %h unacked", dout, prev_out);
            end
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_send: out=%h prev=%h with nothing queued", dout, prev_out);
            end else begin
                exp_v = prev_out ^ exp_q.pop_front();
                if (dout !== exp_v) begin
                    bad++;
                    $display("FAIL send_value: got %h expected %h", dout, exp_v);
                end
            end
            $display("send: out=%h", dout);
            prev_out = dout;
            pending  = 1'b1;
            ack_dly  = $urandom_range(0, 3);
        end else if (pending && ack_en) begin
            if (ack_dly == 0) begin
                ack     = ~ack;
                pending = 1'b0;
            end else begin
                ack_dly--;
            end
        end
    endtask

    task automatic push(input logic [6:0] d);
        bit ok;
        bit r;
        ok  = 1'b0;
        din = d;
        vld = 1'b1;
        for (int i = 0; i < 40 && !ok; i++) begin
            r = rdy;
            tick();
            if (r) ok = 1'b1;
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL push_timeout: flit %h not accepted, rdy=%b", d, rdy);
        end else if ($countones(d) == 2) begin
            exp_q.push_back(d);
        end
        $display("push: flit=%h accepted=%0d", d, ok);
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && (exp_q.size() != 0 || pending); i++) tick();
        total++;
        if (exp_q.size() != 0 || pending) begin
            bad++;
            $display("FAIL drain: %0d flits left, pending=%0d expected 0 and 0", exp_q.size(), pending);
        end
        repeat (4) tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ack   = 1'b1;
        repeat (3) tick();
        total++; if (dout !== 7'd0) begin bad++; $display("FAIL reset_out: got %h expected 00", dout); end
        total++; if (rdy !== 1'b0) begin bad++; $display("FAIL reset_rdy: got %b expected 0", rdy); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b expected 0", err); end
        rst_n = 1'b1;
        din   = rand_flit();
        vld   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (rdy !== 1'b0) begin bad++; $display("FAIL sync_rdy: edge %0d got %b expected 0", i, rdy); end
            tick();
        end
        total++; if (rdy !== 1'b1) begin bad++; $display("FAIL idle_rdy: got %b expected 1", rdy); end
        vld = 1'b0;
        repeat (5) tick();
        total++; if (dout !== 7'd0) begin bad++; $display("FAIL sync_out: got %h expected 00", dout); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL sync_err: got %b expected 0", err); end
        $display("test_reset: done");
    endtask

    task automatic test_basic();
        int s0;
        s0 = sent;
        ack_en = 1'b1;
        push(7'b0010001);
        push(7'b0100010);
        vld = 1'b0;
        drain(100);
        total++; if (dout !== 7'h33) begin bad++; $display("FAIL basic_out: got %h expected 33", dout); end
        total++; if (sent - s0 !== 2) begin bad++; $display("FAIL basic_count: got %0d expected 2", sent - s0); end
    endtask

    task automatic test_full();
        int s0;
        s0 = sent;
        ack_en = 1'b0;
        for (int i = 0; i < 5; i++) push(rand_flit());
        din = rand_flit();
        vld = 1'b1;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (rdy !== 1'b0) begin bad++; $display("FAIL full_rdy: cycle %0d got %b expected 0", i, rdy); end
            tick();
        end
        vld = 1'b0;
        total++; if (sent - s0 !== 1) begin bad++; $display("FAIL full_inflight: got %0d expected 1", sent - s0); end
        ack_en = 1'b1;
        drain(200);
        total++; if (sent - s0 !== 5) begin bad++; $display("FAIL full_count: got %0d expected 5", sent - s0); end
    endtask

    task automatic test_filter();
        int s0;
        s0 = sent;
        ack_en = 1'b1;
        push(rand_flit());
        push(7'b0000111);
        push(7'b0000001);
        push(rand_flit());
        vld = 1'b0;
        drain(200);
        total++; if (sent - s0 !== 2) begin bad++; $display("FAIL filter_count: got %0d expected 2", sent - s0); end
    endtask

    task automatic test_reset_mid();
        logic [6:0] f;
        ack_en = 1'b0;
        for (int i = 0; i < 4; i++) push(rand_flit());
        vld = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        total++; if (dout !== 7'd0) begin bad++; $display("FAIL midrst_out: got %h expected 00", dout); end
        total++; if (rdy !== 1'b0) begin bad++; $display("FAIL midrst_rdy: got %b expected 0", rdy); end
        exp_q.delete();
        prev_out = 7'd0;
        pending  = 1'b0;
        ack      = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        ack_en = 1'b1;
        repeat (8) tick();
        total++; if (dout !== 7'd0) begin bad++; $display("FAIL midrst_empty: got %h expected 00", dout); end
        f = rand_flit();
        push(f);
        vld = 1'b0;
        drain(100);
        total++; if (dout !== f) begin bad++; $display("FAIL midrst_first: got %h expected %h", dout, f); end
    endtask

    task automatic test_timeout();
        int s0;
        bit seen;
        logic [6:0] f1;
        logic [6:0] f2;
        ack_en = 1'b0;
        f1 = rand_flit();
        f2 = rand_flit();
        push(f1);
        push(f2);
        vld = 1'b0;
        s0 = sent;
`ifdef SPIO_SL_TX_TIMEOUT_EN
        seen = 1'b0;
        for (int i = 0; i < TC + 50 && !seen; i++) begin
            tick();
            if (err === 1'b1) seen = 1'b1;
        end
        total++; if (!seen) begin bad++; $display("FAIL timeout_err: got %b expected 1", err); end
        pending = 1'b0;
        for (int i = 0; i < 20 && !pending; i++) tick();
        total++; if (sent - s0 !== 1) begin bad++; $display("FAIL timeout_next: got %0d sends expected 1", sent - s0); end
        total++; if (err !== 1'b1) begin bad++; $display("FAIL timeout_sticky: got %b expected 1", err); end
`else
        seen = 1'b0;
        for (int i = 0; i < TC + 50; i++) begin
            tick();
            if (err !== 1'b0) seen = 1'b1;
        end
        total++; if (seen) begin bad++; $display("FAIL timeout_err: got 1 expected 0"); end
        total++; if (sent - s0 !== 0) begin bad++; $display("FAIL timeout_nosend: got %0d sends expected 0", sent - s0); end
        total++; if (exp_q.size() !== 1) begin bad++; $display("FAIL timeout_queued: got %0d expected 1", exp_q.size()); end
`endif
        $display("test_timeout: done");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full();
        test_filter();
        test_reset_mid();
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
